mem_bus_arbiter: RTL and testbench

- Shares the single external memory port between two cache control units: the instruction-side CMU (master I) and the data-side CMU (master D).
- Grants the port to one master for its whole multi-beat transaction (write-back plus refill). Ownership changes only when the owner drops its chip select.
- Uses round-robin on ties, routes ack only to the owner, and flags stuck transactions with a watchdog.
- Sits between both CMUs' mem-side ports and the memory model or bus bridge.

---
 rtl/mem_bus_arbiter_pkg.sv | 16 +
 rtl/mem_bus_arbiter_arb_rr2.sv | 18 +
 rtl/mem_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and constants for the two-master memory port arbiter.
package mem_bus_arbiter_pkg;

  // Encoding is visible on owner_o, so keep the values fixed.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2
  } arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int DEFAULT_TIMEOUT_W = 8;

endpackage

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// Two-requester round-robin picker: a lone requester wins, a tie goes to
// whichever master did not own the port last.
module arb_rr2
  import mem_bus_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_owner,
  output logic pick
);

  always_comb begin
    pick = OWNER_I;
    if (req_i && req_d) pick = ~last_owner;
    else if (req_d)     pick = OWNER_D;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between the I-side and D-side cache
// control units, holding the grant for a whole multi-beat transaction.
//
// state   | meaning
// S_IDLE  | no owner, memory outputs and acks forced to 0
// S_GNT_I | master I owns the port until it drops i_cs_i
// S_GNT_D | master D owns the port until it drops d_cs_i
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = DEFAULT_TIMEOUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cs_i,
  input  logic              i_we_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic [DATA_W-1:0] i_data_o,
  output logic              i_ack_o,
  input  logic              d_cs_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_ack_o,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        owner_o,
  output logic              err_timeout_o
);

  arb_state_t           state, state_nxt;
  logic                 last_owner, last_owner_nxt;
  logic [TIMEOUT_W-1:0] wdog, wdog_nxt;
  logic                 err_timeout;
  logic                 req_i, req_d, pick, owner_cs;

  // The current owner is masked out, so the same picker serves both the
  // idle decision and the handoff when the owner releases.
  assign req_i = i_cs_i && (state != S_GNT_I);
  assign req_d = d_cs_i && (state != S_GNT_D);

  arb_rr2 u_rr (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_owner (last_owner),
    .pick       (pick)
  );

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      S_IDLE: begin
        if (req_i || req_d) state_nxt = (pick == OWNER_D) ? S_GNT_D : S_GNT_I;
      end
      S_GNT_I: begin
        if (!i_cs_i) begin
          last_owner_nxt = OWNER_I;
          state_nxt      = req_d ? S_GNT_D : S_IDLE;
        end
      end
      S_GNT_D: begin
        if (!d_cs_i) begin
          last_owner_nxt = OWNER_D;
          state_nxt      = req_i ? S_GNT_I : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign owner_cs = ((state == S_GNT_I) && i_cs_i) || ((state == S_GNT_D) && d_cs_i);

  always_comb begin
    wdog_nxt = '0;
    if (owner_cs && !mem_ack_i)
      wdog_nxt = (wdog == {TIMEOUT_W{1'b1}}) ? wdog : wdog + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      last_owner  <= OWNER_D;
      wdog        <= '0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      wdog       <= wdog_nxt;
      if (wdog_nxt == {TIMEOUT_W{1'b1}}) err_timeout <= 1'b1;
    end
  end

  always_comb begin
    mem_cs_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    i_ack_o    = 1'b0;
    d_ack_o    = 1'b0;
    case (state)
      S_GNT_I: begin
        mem_cs_o   = i_cs_i;
        mem_we_o   = i_cs_i & i_we_i;
        mem_addr_o = i_addr_i;
        mem_data_o = i_data_i;
        i_ack_o    = mem_ack_i;
      end
      S_GNT_D: begin
        mem_cs_o   = d_cs_i;
        mem_we_o   = d_cs_i & d_we_i;
        mem_addr_o = d_addr_i;
        mem_data_o = d_data_i;
        d_ack_o    = mem_ack_i;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the acked master consumes it.
  assign i_data_o      = mem_data_i;
  assign d_data_o      = mem_data_i;
  assign owner_o       = state;
  assign err_timeout_o = err_timeout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed + randomized bench for mem_bus_arbiter against a transaction-level
// ownership model (owner as 0/1/2, idle-cycle counter for the watchdog).
module tb_mem_bus_arbiter;

  localparam int TW     = 3;
  localparam int WD_MAX = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cs, i_we, i_ack, d_cs, d_we, d_ack;
  logic [31:0] i_addr, i_wdata, i_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_cs, mem_we, mem_ack, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;

  int vectors = 0;
  int miscompares = 0;

  // reference model: owner 0=idle 1=I 2=D; last holds 1 or 2
  int m_owner, m_last, m_cnt;
  bit m_err;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .i_cs_i(i_cs), .i_we_i(i_we), .i_addr_i(i_addr), .i_data_i(i_wdata),
    .i_data_o(i_rdata), .i_ack_o(i_ack),
    .d_cs_i(d_cs), .d_we_i(d_we), .d_addr_i(d_addr), .d_data_i(d_wdata),
    .d_data_o(d_rdata), .d_ack_o(d_ack),
    .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .owner_o(owner), .err_timeout_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit own_cs;
    if (!rst) begin
      m_owner = 0; m_last = 2; m_cnt = 0; m_err = 0;
    end else begin
      own_cs = (m_owner == 1 && i_cs) || (m_owner == 2 && d_cs);
      if (own_cs && !mem_ack) m_cnt = (m_cnt < WD_MAX) ? m_cnt + 1 : WD_MAX;
      else m_cnt = 0;
      if (m_cnt == WD_MAX) m_err = 1;
      if (m_owner == 0) begin
        if (i_cs && d_cs) m_owner = (m_last == 2) ? 1 : 2;
        else if (i_cs)    m_owner = 1;
        else if (d_cs)    m_owner = 2;
      end else if (m_owner == 1 && !i_cs) begin
        m_last = 1; m_owner = d_cs ? 2 : 0;
      end else if (m_owner == 2 && !d_cs) begin
        m_last = 2; m_owner = i_cs ? 1 : 0;
      end
    end
  endtask

  task automatic cycle();
    logic [31:0] e_cs, e_we, e_addr, e_dat, e_iack, e_dack;
    @(negedge clk);
    e_cs = 0; e_we = 0; e_addr = 0; e_dat = 0; e_iack = 0; e_dack = 0;
    if (m_owner == 1) begin
      e_cs = i_cs; e_we = i_cs & i_we; e_addr = i_addr; e_dat = i_wdata; e_iack = mem_ack;
    end else if (m_owner == 2) begin
      e_cs = d_cs; e_we = d_cs & d_we; e_addr = d_addr; e_dat = d_wdata; e_dack = mem_ack;
    end
    chk("owner",    32'(owner),  32'(m_owner));
    chk("mem_cs",   32'(mem_cs), e_cs);
    chk("mem_we",   32'(mem_we), e_we);
    chk("mem_addr", mem_addr,    e_addr);
    chk("mem_data", mem_wdata,   e_dat);
    chk("i_ack",    32'(i_ack),  e_iack);
    chk("d_ack",    32'(d_ack),  e_dack);
    chk("i_rdata",  i_rdata,     mem_rdata);
    chk("d_rdata",  d_rdata,     mem_rdata);
    chk("err",      32'(err),    32'(m_err));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    i_cs = 0; i_we = 0; i_addr = 0; i_wdata = 0;
    d_cs = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 0;
    cycle();
    rst = 1;
  endtask

  initial begin
    int bi, bd, gk, prev;
    rst = 0;
    quiet();
    @(posedge clk); #1;
    m_owner = 0; m_last = 2; m_cnt = 0; m_err = 0;
    cycle();
    chk("reset_owner", 32'(owner), 0);
    chk("reset_cs", 32'(mem_cs), 0);
    rst = 1;

    // single I read burst
    i_cs = 1; i_we = 0; i_addr = 32'h100;
    cycle();
    chk("t1_owner", 32'(owner), 1);
    chk("t1_cs", 32'(mem_cs), 1);
    for (int b = 0; b < 4; b++) begin
      i_addr = 32'h100 + 32'(4 * b);
      mem_ack = 1; mem_rdata = 32'hA0 + 32'(b);
      cycle();
    end
    i_cs = 0; mem_ack = 0;
    cycle();
    chk("t1_release", 32'(owner), 0);

    // simultaneous first request after reset
    do_reset();
    i_cs = 1; d_cs = 1; i_addr = 32'h200; d_addr = 32'h300;
    cycle();
    chk("t2_first", 32'(owner), 1);
    mem_ack = 1;
    cycle(); cycle();
    i_cs = 0;
    cycle();
    chk("t2_handoff", 32'(owner), 2);
    d_cs = 0; mem_ack = 0;
    cycle();

    // D write-back + refill with I arriving mid-burst
    do_reset();
    d_cs = 1; d_we = 1; d_addr = 32'h400;
    cycle();
    for (int b = 0; b < 8; b++) begin
      d_we = (b < 4); d_addr = 32'h400 + 32'(4 * b); d_wdata = $urandom;
      mem_ack = 1; mem_rdata = $urandom;
      if (b == 2) i_cs = 1;
      cycle();
      chk("t3_locked", 32'(owner), 2);
    end
    d_cs = 0; mem_ack = 0;
    cycle();
    chk("t3_then_i", 32'(owner), 1);
    i_cs = 0;
    cycle();

    // alternating ties, 4 beats each
    do_reset();
    bi = 0; bd = 0; gk = 0; prev = 0; mem_ack = 1;
    repeat (40) begin
      i_cs = 1; d_cs = 1;
      if (m_owner == 1 && bi == 4) begin i_cs = 0; bi = 0; end
      if (m_owner == 2 && bd == 4) begin d_cs = 0; bd = 0; end
      mem_rdata = $urandom; i_addr = $urandom; d_addr = $urandom;
      if (m_owner == 1 && i_cs) bi++;
      if (m_owner == 2 && d_cs) bd++;
      cycle();
      if (owner != 2'(prev) && owner != 2'd0) begin
        chk("t4_alternate", 32'(owner), (gk % 2 == 0) ? 1 : 2);
        gk++;
      end
      prev = int'(owner);
    end
    quiet();
    cycle(); cycle();

    // watchdog
    do_reset();
    i_cs = 1;
    repeat (9) cycle();
    chk("t5_err_set", 32'(err), 1);
    mem_ack = 1;
    cycle();
    mem_ack = 0;
    cycle();
    chk("t5_err_sticky", 32'(err), 1);
    rst = 0;
    cycle();
    chk("t5_err_clear", 32'(err), 0);
    rst = 1; i_cs = 0;
    cycle();

    // reset mid-burst
    do_reset();
    d_cs = 1; d_addr = 32'h500;
    cycle();
    mem_ack = 1;
    cycle(); cycle();
    rst = 0; i_cs = 1;
    cycle();
    chk("t6_owner", 32'(owner), 0);
    chk("t6_cs", 32'(mem_cs), 0);
    chk("t6_dack", 32'(d_ack), 0);
    chk("t6_err", 32'(err), 0);
    rst = 1;
    cycle();
    chk("t6_i_first", 32'(owner), 1);
    quiet();
    cycle(); cycle();

    // randomized traffic
    repeat (500) begin
      if ($urandom_range(0, 5) == 0) i_cs = ~i_cs;
      if ($urandom_range(0, 5) == 0) d_cs = ~d_cs;
      i_we = 1'($urandom); d_we = 1'($urandom);
      i_addr = $urandom; d_addr = $urandom;
      i_wdata = $urandom; d_wdata = $urandom;
      mem_rdata = $urandom;
      mem_ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 79) != 0);
      cycle();
    end
    rst = 1;
    quiet();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
